// File: rtl/crc_frame_engine.sv
// Word-parallel framed CRC generator/checker, DW bits per beat, MSB first.
// Optional protocol-error reporting (o_err, o_err_cnt) enabled by defining CRC_FRAME_ERR_EN.
module crc_frame_engine #(
  parameter int unsigned    CW     = 8,
  parameter logic [CW-1:0]  POLY   = CW'(8'h2F),
  parameter logic [CW-1:0]  INIT   = CW'(8'hFF),
  parameter logic [CW-1:0]  XOROUT = CW'(8'h00),
  parameter int unsigned    DW     = 8,
  parameter int unsigned    NBW    = $clog2(DW / 8) + 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_vld,
  output logic           o_rdy,
  input  logic [DW-1:0]  i_data,
  input  logic           i_sof,
  input  logic           i_eof,
  input  logic [NBW-1:0] i_nbytes,
  input  logic           i_chk,
  output logic           o_crc_vld,
  output logic [CW-1:0]  o_crc,
  output logic           o_crc_ok,
`ifdef CRC_FRAME_ERR_EN
  output logic           o_err,
  output logic [7:0]     o_err_cnt,
`endif
  input  logic           i_ack
);

  localparam int unsigned NB = DW / 8;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e        state_q;
  logic [CW-1:0] reg_q;
  logic [CW-1:0] crc_q;
  logic          ok_q;
  logic          vld_q;
  logic          rdy_q;
  logic          chk_q;

  logic          take;
  logic          nb_over;
  logic          chk_eff;
  int unsigned   nb_eff;
  logic [CW-1:0] seed;
  logic [CW-1:0] reg_nxt;

  // Feeds the top 8*nb bits of d into r, one bit at a time, MSB first.
  function automatic logic [CW-1:0] crc_step(input logic [CW-1:0] r, input logic [DW-1:0] d,
                                             input int unsigned nb);
    logic [CW-1:0] c;
    logic          fb;
    c  = r;
    fb = 1'b0;
    for (int unsigned k = 0; k < DW; k++) begin
      if (k / 8 < nb) begin
        fb = c[CW-1] ^ d[DW-1-k];
        c  = (c << 1) ^ (fb ? POLY : '0);
      end
    end
    return c;
  endfunction

  assign take    = i_vld & rdy_q;
  assign nb_over = i_eof && (32'(i_nbytes) > NB);
  assign chk_eff = i_sof ? i_chk : chk_q;

  always_comb begin
    nb_eff = NB;
    if (i_eof && (i_nbytes != '0) && !nb_over) nb_eff = 32'(i_nbytes);
    seed    = i_sof ? INIT : reg_q;
    reg_nxt = crc_step(seed, i_data, nb_eff);
  end

`ifdef CRC_FRAME_ERR_EN
  logic       err_now;
  logic       err_q;
  logic [7:0] err_cnt_q;

  assign err_now = take & (((state_q == StIdle) & ~i_sof) | ((state_q == StCalc) & i_sof) |
                           nb_over);
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      err_q <= err_now;
      if (err_now && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      reg_q   <= INIT;
      crc_q   <= INIT ^ XOROUT;
      ok_q    <= 1'b0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
      chk_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StCalc: begin
          // A beat without sof while idle belongs to no frame and is dropped.
          if (take && !((state_q == StIdle) && !i_sof)) begin
            reg_q <= reg_nxt;
            crc_q <= reg_nxt ^ XOROUT;
            if (i_sof) chk_q <= i_chk;
            if (i_eof) begin
              state_q <= StDone;
              rdy_q   <= 1'b0;
              vld_q   <= 1'b1;
              ok_q    <= chk_eff && (reg_nxt == '0);
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StDone: begin
          if (i_ack) begin
            state_q <= StIdle;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            ok_q    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_rdy     = rdy_q;
  assign o_crc_vld = vld_q;
  assign o_crc     = crc_q;
  assign o_crc_ok  = ok_q;

endmodule
